// File: rtl/sorted_stream_out.sv
// sorted_stream_out: captures a sorted vector in one cycle and streams it out one element per cycle
module sorted_stream_out #(
    parameter int WIDTH = 3,
    parameter int n = 128,
    parameter int IDXW = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   desc,
    input  logic [2*n*WIDTH-1:0]   c_in,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [IDXW-1:0]        out_idx,
    output logic                   out_valid,
    output logic                   out_last,
    output logic                   busy,
    output logic                   overflow
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;
    localparam logic [IDXW-1:0] LAST = IDXW'(2 * n - 1);

    logic [0:0]           state;
    logic [2*n*WIDTH-1:0] cbuf;
    logic                 dir;
    logic [IDXW-1:0]      idx;
    logic                 streaming, fin, xfer, take;

    always_comb begin
        streaming = state == STREAM;
        fin = streaming && (dir ? idx == '0 : idx == LAST);
        xfer = streaming && out_ready;
        take = start && (!streaming || (xfer && fin));
    end

    assign out_valid = streaming;
    assign out_last = fin;
    assign busy = streaming;
    assign out_idx = streaming ? idx : '0;
    assign out_data = streaming ? cbuf[WIDTH*int'(idx) +: WIDTH] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cbuf <= '0;
            dir <= 1'b0;
            idx <= '0;
            overflow <= 1'b0;
        end else if (take) begin
            state <= STREAM;
            cbuf <= c_in;
            dir <= desc;
            idx <= desc ? LAST : '0;
        end else begin
            // a start here is neither from IDLE nor on the last transfer, so it is dropped
            if (start && streaming) overflow <= 1'b1;
            if (xfer) begin
                if (fin) state <= IDLE;
                else idx <= dir ? idx - 1'b1 : idx + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sorted_stream_out.sv
// tb_sorted_stream_out: directed checks of capture, streaming order, stalls, overflow and back-to-back
module tb_sorted_stream_out;
    localparam int WIDTH = 3;
    localparam int n = 128;
    localparam int IDXW = 8;

    logic clk, rst, start, desc, out_ready;
    logic [2*n*WIDTH-1:0] c_in, asc, sevens;
    logic [WIDTH-1:0] out_data;
    logic [IDXW-1:0] out_idx;
    logic out_valid, out_last, busy, overflow;
    int compared = 0;
    int mismatched = 0;

    sorted_stream_out #(.WIDTH(WIDTH), .n(n), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .start(start), .desc(desc), .c_in(c_in),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_valid(out_valid), .out_last(out_last), .busy(busy), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic d, input logic [2*n*WIDTH-1:0] v);
        @(negedge clk);
        start = 1'b1;
        desc = d;
        c_in = v;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_elem(input string tag, input int e);
        check({tag, "_valid"}, 32'(out_valid), 1);
        check({tag, "_idx"}, 32'(out_idx), 32'(e));
        check({tag, "_data"}, 32'(out_data), 32'(e >> 5));
        check({tag, "_last"}, 32'(out_last), 32'(e == 2 * n - 1));
    endtask

    initial begin
        for (int k = 0; k < 2 * n; k++) begin
            asc[k*WIDTH +: WIDTH] = WIDTH'(k >> 5);
            sevens[k*WIDTH +: WIDTH] = 3'd7;
        end
        rst = 1'b0;
        start = 1'b1;
        desc = 1'b0;
        c_in = asc;
        out_ready = 1'b1;

        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_valid", 32'(out_valid), 0);
            check("rst_busy", 32'(busy), 0);
            check("rst_ovf", 32'(overflow), 0);
            check("rst_data", 32'(out_data), 0);
        end
        rst = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 0);

        pulse_start(1'b0, asc);
        for (int i = 0; i < 2 * n; i++) begin
            @(negedge clk);
            check_elem("asc", i);
        end
        @(negedge clk);
        check("asc_end_busy", 32'(busy), 0);
        check("asc_end_valid", 32'(out_valid), 0);
        check("asc_end_idx", 32'(out_idx), 0);

        begin
            int e = 2 * n - 1;
            bit done = 0;
            logic [3:0] pat = 4'b1001;
            pulse_start(1'b1, asc);
            for (int c = 0; c < 4000 && !done; c++) begin
                @(negedge clk);
                out_ready = pat[c % 4];
                check("dsc_valid", 32'(out_valid), 1);
                check("dsc_idx", 32'(out_idx), 32'(e));
                check("dsc_data", 32'(out_data), 32'(e >> 5));
                check("dsc_last", 32'(out_last), 32'(e == 0));
                @(posedge clk);
                if (out_ready) begin
                    if (e == 0) done = 1;
                    else e--;
                end
            end
            check("dsc_done", 32'(done), 1);
            out_ready = 1'b1;
            @(negedge clk);
            check("dsc_end_busy", 32'(busy), 0);
        end

        pulse_start(1'b0, asc);
        for (int i = 0; i < 2 * n; i++) begin
            @(negedge clk);
            check_elem("ovf", i);
            if (i == 10) begin
                check("ovf_before", 32'(overflow), 0);
                start = 1'b1;
                c_in = sevens;
                desc = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
                c_in = asc;
                desc = 1'b0;
            end
            if (i == 11) check("ovf_set", 32'(overflow), 1);
        end
        @(negedge clk);
        check("ovf_idle_busy", 32'(busy), 0);
        check("ovf_sticky", 32'(overflow), 1);

        pulse_start(1'b0, asc);
        for (int i = 0; i <= 100; i++) begin
            @(negedge clk);
            check_elem("mid", i);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_ovf", 32'(overflow), 0);
        @(negedge clk);
        check("mid_rst_hold", 32'(out_valid), 0);

        pulse_start(1'b0, asc);
        for (int i = 0; i < 2 * n; i++) begin
            @(negedge clk);
            check_elem("b2b", i);
        end
        start = 1'b1;
        c_in = sevens;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("b2b_idx", 32'(out_idx), 0);
        check("b2b_data", 32'(out_data), 7);
        check("b2b_busy", 32'(busy), 1);
        check("b2b_valid", 32'(out_valid), 1);
        check("b2b_ovf", 32'(overflow), 0);
        begin
            int c = 0;
            while (busy && c < 1000) begin
                @(negedge clk);
                c++;
            end
            check("b2b_finish", 32'(busy), 0);
            check("b2b_len", 32'(c), 2 * n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
